tinker_io_port: RTL and testbench
=================================

Name: tinker_io_port

Overview:
Memory-less I/O bridge directly downstream of the Tinker CPU's in/out port pins (opcodes 29/30). It buffers words the CPU emits on its output port into a TX FIFO drained by the host/testbench over a valid/ready handshake. It buffers host-supplied words into an RX FIFO presented to the CPU's in_data. Sticky overflow/underflow flags report misuse; the CPU top-level ORs them into its error/halt.

Parameters:
WIDTH, 64, data word width (matches CPU register width)
DEPTH, 8, entries per FIFO; power of two, >= 2
CW, $clog2(DEPTH)+1, occupancy counter width (derived, localparam)

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  asynchronous, active-high; clears all state
cpu_out_signal  input  1  one-cycle strobe: push cpu_out_data into TX FIFO
cpu_out_data  input  WIDTH  word from CPU output port
cpu_in_signal  input  1  one-cycle strobe: CPU consumed cpu_in_data; pop RX FIFO
cpu_in_data  output  WIDTH  head of RX FIFO (show-ahead); 0 when RX empty
cpu_in_avail  output  1  RX FIFO non-empty
host_tx_data  output  WIDTH  head of TX FIFO; 0 when TX empty
host_tx_valid  output  1  TX FIFO non-empty
host_tx_ready  input  1  host accepts host_tx_data this cycle
host_rx_data  input  WIDTH  word from host for CPU
host_rx_valid  input  1  host offers host_rx_data
host_rx_ready  output  1  RX FIFO not full
tx_count  output  CW  TX occupancy 0..DEPTH
rx_count  output  CW  RX occupancy 0..DEPTH
err_clear  input  1  synchronous clear of sticky flags
tx_overflow  output  1  sticky: CPU pushed while TX full, no pop same cycle
rx_underflow  output  1  sticky: CPU strobed cpu_in_signal while RX empty

Behaviour:
- Reset (async assert, sync-safe deassert on clk): read/write pointers, counts, flags = 0; all outputs 0; host_rx_ready = 1 after reset, since it is derived from the RX count. FIFO storage contents need not clear.
- Each FIFO: circular buffer, pointers log2(DEPTH) bits, wrap DEPTH-1 -> 0 naturally. Count tracks occupancy; full = (count == DEPTH), empty = (count == 0).
- Outputs combinational from state: cpu_in_data/host_tx_data = mem[rd_ptr] when non-empty, else 0. Valid/avail/ready/count direct from registers.
- Latency: a word pushed at edge N is visible at the opposite head after edge N (same cycle as count update); minimum push-to-pop latency is 1 cycle.
- TX push: cpu_out_signal=1 at posedge.
  - Not full: write the word, advance wr_ptr.
  - Full and host_tx_valid & host_tx_ready the same cycle: push and pop both occur; count unchanged.
  - Full with no pop: word dropped, tx_overflow <= 1, state unchanged.
- TX pop: host_tx_valid & host_tx_ready at posedge advances rd_ptr. host_tx_ready while empty is ignored and raises no flag.
- RX push: host_rx_valid & host_rx_ready. A host never pushes into a full FIFO, because the handshake blocks it. A pop and push in the same cycle while full are NOT merged: ready is low, so the push does not occur.
- RX pop: cpu_in_signal=1.
  - Non-empty: advance rd_ptr.
  - Empty: rx_underflow <= 1, no pointer change. A push arriving the same cycle is still accepted; it does not satisfy the pop.
- Simultaneous push+pop on a non-empty, non-full FIFO: both happen, count unchanged. On an empty FIFO, a push+pop leaves the new word stored; the pop is an underflow (RX) or ignored (TX).
- err_clear: clears both flags at next edge. If a new error occurs in the same cycle, the flag stays/sets to 1 (set wins).
- Counts never exceed DEPTH or go below 0 under any input combination.
- Reset mid-operation: pending words discarded, outputs return to reset values asynchronously.

Test Plan:
- Reset then idle -> all outputs 0 except host_rx_ready=1; tx_count=rx_count=0.
- CPU strobes 3 words 0x11,0x22,0x33 with host_tx_ready=0, then ready=1 for 3 cycles -> host_tx_data 0x11,0x22,0x33 in order; tx_count 3->0; host_tx_valid drops after the third accept.
- Fill TX with 8 words (DEPTH=8), strobe 9th 0xDEAD with ready=0 -> dropped, tx_overflow=1, tx_count=8. Repeat with ready=1 on the push cycle -> accepted, no flag, count stays 8. err_clear -> tx_overflow=0.
- Host pushes 0xA5 -> next cycle cpu_in_avail=1, cpu_in_data=0xA5. cpu_in_signal -> rx_count=0, cpu_in_data=0. Another cpu_in_signal -> rx_underflow=1.
- Pointer wrap: 20 push/pop pairs through RX with values 1..20 -> outputs 1..20 in order, rx_count never >DEPTH; host_rx_ready low exactly while rx_count=8.
- Assert reset asynchronously between edges with both FIFOs half full -> counts, flags, valids drop to 0 immediately; after release, the FIFOs behave as empty.

Source files
------------

// File: rtl/tinker_io_port.sv
// I/O bridge between the Tinker CPU in/out port pins and a host: a TX FIFO
// carries CPU output words to the host, and an RX FIFO carries host words to the CPU.
module tinker_io_port #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_out_signal,
  input  logic [WIDTH-1:0] cpu_out_data,
  input  logic             cpu_in_signal,
  output logic [WIDTH-1:0] cpu_in_data,
  output logic             cpu_in_avail,
  output logic [WIDTH-1:0] host_tx_data,
  output logic             host_tx_valid,
  input  logic             host_tx_ready,
  input  logic [WIDTH-1:0] host_rx_data,
  input  logic             host_rx_valid,
  output logic             host_rx_ready,
  output logic [CW-1:0]    tx_count,
  output logic [CW-1:0]    rx_count,
  input  logic             err_clear,
  output logic             tx_overflow,
  output logic             rx_underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] tx_mem [DEPTH];
  logic [WIDTH-1:0] rx_mem [DEPTH];
  logic [PW-1:0]    tx_wr, tx_rd, rx_wr, rx_rd;
  logic [CW-1:0]    tx_cnt, rx_cnt;
  logic             tx_ovf_q, rx_udf_q;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic tx_ovf_evt, rx_udf_evt;

  function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] cnt,
                                             input logic push, input logic pop);
    logic [CW-1:0] res;
    res = cnt;
    case ({push, pop})
      2'b10:   res = cnt + CW'(1);
      2'b01:   res = cnt - CW'(1);
      default: res = cnt;
    endcase
    return res;
  endfunction

  assign tx_full  = (tx_cnt == FULL_CNT);
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == FULL_CNT);
  assign rx_empty = (rx_cnt == '0);

  // A full TX FIFO still takes a CPU word when the host drains one in the same cycle.
  assign tx_pop     = !tx_empty && host_tx_ready;
  assign tx_push    = cpu_out_signal && (!tx_full || tx_pop);
  assign tx_ovf_evt = cpu_out_signal && tx_full && !tx_pop;

  // RX push is gated by ready alone; a same-cycle CPU pop does not open a full FIFO.
  assign rx_push    = host_rx_valid && !rx_full;
  assign rx_pop     = cpu_in_signal && !rx_empty;
  assign rx_udf_evt = cpu_in_signal && rx_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_cnt   <= '0;
      rx_wr    <= '0;
      rx_rd    <= '0;
      rx_cnt   <= '0;
      tx_ovf_q <= 1'b0;
      rx_udf_q <= 1'b0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + PW'(1);
      if (tx_pop)  tx_rd <= tx_rd + PW'(1);
      if (rx_push) rx_wr <= rx_wr + PW'(1);
      if (rx_pop)  rx_rd <= rx_rd + PW'(1);
      tx_cnt <= cnt_next(tx_cnt, tx_push, tx_pop);
      rx_cnt <= cnt_next(rx_cnt, rx_push, rx_pop);
      if (tx_ovf_evt)     tx_ovf_q <= 1'b1;
      else if (err_clear) tx_ovf_q <= 1'b0;
      if (rx_udf_evt)     rx_udf_q <= 1'b1;
      else if (err_clear) rx_udf_q <= 1'b0;
    end
  end

  // Storage is never reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= cpu_out_data;
    if (rx_push) rx_mem[rx_wr] <= host_rx_data;
  end

  assign host_tx_data  = tx_empty ? '0 : tx_mem[tx_rd];
  assign host_tx_valid = !tx_empty;
  assign cpu_in_data   = rx_empty ? '0 : rx_mem[rx_rd];
  assign cpu_in_avail  = !rx_empty;
  assign host_rx_ready = !rx_full;
  assign tx_count      = tx_cnt;
  assign rx_count      = rx_cnt;
  assign tx_overflow   = tx_ovf_q;
  assign rx_underflow  = rx_udf_q;

endmodule

// File: tb/tb_tinker_io_port.sv
// Bench for tinker_io_port: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_tinker_io_port;
  localparam int WIDTH = 64;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             cpu_out_signal;
  logic [WIDTH-1:0] cpu_out_data;
  logic             cpu_in_signal;
  logic [WIDTH-1:0] cpu_in_data;
  logic             cpu_in_avail;
  logic [WIDTH-1:0] host_tx_data;
  logic             host_tx_valid;
  logic             host_tx_ready;
  logic [WIDTH-1:0] host_rx_data;
  logic             host_rx_valid;
  logic             host_rx_ready;
  logic [CW-1:0]    tx_count;
  logic [CW-1:0]    rx_count;
  logic             err_clear;
  logic             tx_overflow;
  logic             rx_underflow;

  tinker_io_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cpu_out_signal(cpu_out_signal), .cpu_out_data(cpu_out_data),
    .cpu_in_signal(cpu_in_signal), .cpu_in_data(cpu_in_data),
    .cpu_in_avail(cpu_in_avail),
    .host_tx_data(host_tx_data), .host_tx_valid(host_tx_valid),
    .host_tx_ready(host_tx_ready),
    .host_rx_data(host_rx_data), .host_rx_valid(host_rx_valid),
    .host_rx_ready(host_rx_ready),
    .tx_count(tx_count), .rx_count(rx_count),
    .err_clear(err_clear), .tx_overflow(tx_overflow), .rx_underflow(rx_underflow)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b0;

  logic [WIDTH-1:0] txq[$];
  logic [WIDTH-1:0] rxq[$];
  bit m_tx_ovf, m_rx_udf;

  task automatic chk(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("tx_count", WIDTH'(tx_count), WIDTH'(txq.size()));
      chk("rx_count", WIDTH'(rx_count), WIDTH'(rxq.size()));
      chk("host_tx_valid", WIDTH'(host_tx_valid), WIDTH'(txq.size() != 0));
      chk("cpu_in_avail", WIDTH'(cpu_in_avail), WIDTH'(rxq.size() != 0));
      chk("host_rx_ready", WIDTH'(host_rx_ready), WIDTH'(rxq.size() < DEPTH));
      chk("host_tx_data", host_tx_data, (txq.size() != 0) ? txq[0] : '0);
      chk("cpu_in_data", cpu_in_data, (rxq.size() != 0) ? rxq[0] : '0);
      chk("tx_overflow", WIDTH'(tx_overflow), WIDTH'(m_tx_ovf));
      chk("rx_underflow", WIDTH'(rx_underflow), WIDTH'(m_rx_udf));
    end
  end

  task automatic model_clear();
    txq.delete();
    rxq.delete();
    m_tx_ovf = 1'b0;
    m_rx_udf = 1'b0;
  endtask

  task automatic model_update();
    bit tx_pop, rx_push, ovf_e, udf_e;
    tx_pop  = (txq.size() != 0) && host_tx_ready;
    rx_push = host_rx_valid && (rxq.size() < DEPTH);
    ovf_e   = 1'b0;
    udf_e   = 1'b0;
    if (tx_pop) void'(txq.pop_front());
    if (cpu_out_signal) begin
      if (txq.size() < DEPTH) txq.push_back(cpu_out_data);
      else ovf_e = 1'b1;
    end
    if (cpu_in_signal) begin
      if (rxq.size() != 0) void'(rxq.pop_front());
      else udf_e = 1'b1;
    end
    if (rx_push) rxq.push_back(host_rx_data);
    if (ovf_e) m_tx_ovf = 1'b1;
    else if (err_clear) m_tx_ovf = 1'b0;
    if (udf_e) m_rx_udf = 1'b1;
    else if (err_clear) m_rx_udf = 1'b0;
  endtask

  // One clock: model advances with the inputs held this cycle; returns 1 after the edge.
  task automatic step();
    @(negedge clk);
    #1;
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_out_signal = 1'b0;
    cpu_out_data   = '0;
    cpu_in_signal  = 1'b0;
    host_tx_ready  = 1'b0;
    host_rx_data   = '0;
    host_rx_valid  = 1'b0;
    err_clear      = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Reset state
    chk("rst host_rx_ready", WIDTH'(host_rx_ready), WIDTH'(1));
    chk("rst tx_count", WIDTH'(tx_count), '0);
    chk("rst rx_count", WIDTH'(rx_count), '0);
    chk("rst host_tx_valid", WIDTH'(host_tx_valid), '0);
    chk("rst cpu_in_data", cpu_in_data, '0);
    chk("rst flags", WIDTH'({tx_overflow, rx_underflow}), '0);
    step();

    // TX ordering
    for (int i = 1; i <= 3; i++) begin
      cpu_out_signal = 1'b1;
      cpu_out_data   = WIDTH'(i * 'h11);
      step();
    end
    idle_inputs();
    chk("tx3 count", WIDTH'(tx_count), 3);
    chk("tx3 head", host_tx_data, 'h11);
    host_tx_ready = 1'b1;
    step();
    chk("tx pop1 head", host_tx_data, 'h22);
    step();
    chk("tx pop2 head", host_tx_data, 'h33);
    step();
    chk("tx drained valid", WIDTH'(host_tx_valid), '0);
    chk("tx drained count", WIDTH'(tx_count), '0);
    idle_inputs();

    // TX overflow, full push with pop, err_clear, set-wins
    for (int i = 1; i <= DEPTH; i++) begin
      cpu_out_signal = 1'b1;
      cpu_out_data   = WIDTH'(i);
      step();
    end
    cpu_out_data = 'hDEAD;
    step();
    idle_inputs();
    chk("ovf flag", WIDTH'(tx_overflow), 1);
    chk("ovf count", WIDTH'(tx_count), DEPTH);
    chk("ovf head", host_tx_data, 1);
    err_clear = 1'b1;
    step();
    idle_inputs();
    chk("ovf cleared", WIDTH'(tx_overflow), 0);
    cpu_out_signal = 1'b1;
    cpu_out_data   = 'hBEEF;
    host_tx_ready  = 1'b1;
    step();
    idle_inputs();
    chk("full push+pop count", WIDTH'(tx_count), DEPTH);
    chk("full push+pop head", host_tx_data, 2);
    chk("full push+pop no flag", WIDTH'(tx_overflow), 0);
    cpu_out_signal = 1'b1;
    cpu_out_data   = 'h77;
    err_clear      = 1'b1;
    step();
    idle_inputs();
    chk("set wins over clear", WIDTH'(tx_overflow), 1);
    host_tx_ready = 1'b1;
    repeat (DEPTH) step();
    idle_inputs();
    chk("tx drain count", WIDTH'(tx_count), 0);
    err_clear = 1'b1;
    step();
    idle_inputs();

    // RX single word and underflow
    host_rx_valid = 1'b1;
    host_rx_data  = 'hA5;
    step();
    idle_inputs();
    chk("rx avail", WIDTH'(cpu_in_avail), 1);
    chk("rx data", cpu_in_data, 'hA5);
    cpu_in_signal = 1'b1;
    step();
    chk("rx popped count", WIDTH'(rx_count), 0);
    chk("rx popped data", cpu_in_data, 0);
    step();
    idle_inputs();
    chk("rx underflow", WIDTH'(rx_underflow), 1);
    err_clear = 1'b1;
    step();
    idle_inputs();

    // RX fill, non-merged full push+pop, pointer wrap with 1..20
    for (int v = 1; v <= DEPTH; v++) begin
      host_rx_valid = 1'b1;
      host_rx_data  = WIDTH'(v);
      step();
    end
    chk("rx full ready", WIDTH'(host_rx_ready), 0);
    chk("rx full count", WIDTH'(rx_count), DEPTH);
    host_rx_data  = 'd99;
    cpu_in_signal = 1'b1;
    step();
    chk("rx full no merge count", WIDTH'(rx_count), DEPTH - 1);
    chk("rx full no merge head", cpu_in_data, 2);
    for (int v = DEPTH + 1; v <= 20; v++) begin
      host_rx_data = WIDTH'(v);
      step();
    end
    host_rx_valid = 1'b0;
    chk("rx wrap head", cpu_in_data, 20 - DEPTH + 2);
    repeat (DEPTH - 1) step();
    idle_inputs();
    chk("rx wrap drained", WIDTH'(rx_count), 0);

    // Asynchronous reset with both FIFOs half full
    for (int i = 0; i < DEPTH / 2; i++) begin
      cpu_out_signal = 1'b1;
      cpu_out_data   = WIDTH'(100 + i);
      host_rx_valid  = 1'b1;
      host_rx_data   = WIDTH'(200 + i);
      step();
    end
    idle_inputs();
    #1 reset = 1'b1;
    #1;
    chk("async tx_count", WIDTH'(tx_count), 0);
    chk("async rx_count", WIDTH'(rx_count), 0);
    chk("async valids", WIDTH'({host_tx_valid, cpu_in_avail}), 0);
    chk("async ready", WIDTH'(host_rx_ready), 1);
    model_clear();
    @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    cpu_in_signal = 1'b1;
    step();
    idle_inputs();
    chk("post reset underflow", WIDTH'(rx_underflow), 1);

    // Randomized traffic in phases of varying pressure
    for (int ph = 0; ph < 6; ph++) begin
      int p_out, p_rdy, p_rxv, p_in;
      p_out = $urandom_range(10, 90);
      p_rdy = $urandom_range(10, 90);
      p_rxv = $urandom_range(10, 90);
      p_in  = $urandom_range(10, 90);
      for (int c = 0; c < 400; c++) begin
        cpu_out_signal = ($urandom_range(0, 99) < p_out);
        cpu_out_data   = {$urandom, $urandom};
        host_tx_ready  = ($urandom_range(0, 99) < p_rdy);
        host_rx_valid  = ($urandom_range(0, 99) < p_rxv);
        host_rx_data   = {$urandom, $urandom};
        cpu_in_signal  = ($urandom_range(0, 99) < p_in);
        err_clear      = ($urandom_range(0, 99) < 5);
        step();
      end
    end
    idle_inputs();
    step();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
